instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage that sits directly upstream of Instruction_Memory and feeds the decode/register-file top.
- Owns the program counter and drives Inst_Address.
- Captures the returned Instruction together with its PC into a small FIFO.
- Presents {PC, instruction} to decode over a valid/ready handshake.
- Supports backpressure and a branch/jump redirect that flushes in-flight entries.

Parameters:
XLEN, 64, address and PC width
ILEN, 32, instruction width
DEPTH, 2, fetch FIFO entries; power of two, minimum 2
RESET_PC, 64'd0, PC value loaded on reset; must be 4-byte aligned

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
Inst_Address  output  XLEN  current PC sent to Instruction_Memory (combinational read)
Instruction  input  ILEN  instruction word at Inst_Address, valid same cycle
redirect  input  1  branch/jump taken; one-cycle pulse from execute
redirect_target  input  XLEN  new PC when redirect=1
out_valid  output  1  head FIFO entry available to decode
out_ready  input  1  decode accepts head entry this cycle
out_pc  output  XLEN  PC of head entry
out_instr  output  ILEN  instruction of head entry
misaligned  output  1  one-cycle pulse: redirect_target[1:0] was nonzero

Behaviour:
Reset (async, while reset=1):
- pc=RESET_PC; count=0; rd_ptr=wr_ptr=0; misaligned=0.
- Inst_Address=RESET_PC, out_valid=0, out_pc=0, out_instr=0.
- Reset mid-operation discards all FIFO contents. Fetch resumes at RESET_PC on the first edge after deassertion.

Inst_Address is always equal to the pc register (no combinational input path).

Transfer (deq): out_valid & out_ready.
- out_valid = (count!=0) & ~redirect.
- out_pc/out_instr = entry at rd_ptr. They are driven 0 when count==0.

Fetch (enq) occurs when ~redirect & (count<DEPTH | deq).
- Writes {pc, Instruction} at wr_ptr and increments wr_ptr.
- pc <= pc + 4, modulo 2^XLEN: 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- Otherwise pc holds, so Inst_Address is stable under backpressure.

Count update:
- +1 on enq only; -1 on deq only; unchanged on simultaneous enq+deq.
- Full with deq allowed: the freed slot is refilled in the same cycle.

Latency: the instruction at PC=A is presented at Inst_Address in cycle n and appears on out_pc/out_instr in cycle n+1 if the FIFO was empty. Sustained throughput is 1 instruction/cycle with out_ready=1.

Redirect (highest priority):
- Next edge: count=0, rd_ptr=wr_ptr=0, pc <= {redirect_target[XLEN-1:2], 2'b00}.
- No enq and no deq that cycle; out_valid is forced 0, so decode sees no transfer.
- misaligned <= (redirect_target[1:0]!=0) for exactly one cycle; it returns to 0 the following cycle unless redirected again.
- Back-to-back redirects: the last one wins.

Boundaries:
- Empty + out_ready=1: no transfer.
- Full + out_ready=0: pc and FIFO hold indefinitely.
- Pointers are log2(DEPTH) bits and wrap naturally.

Decomposition:
Shared package fetch_pkg holds:
- constants XLEN=64, ILEN=32, INSTR_BYTES=4;
- a typedef fetch_entry_t {pc[XLEN-1:0], instr[ILEN-1:0]}.

One sub-module, fetch_fifo (parameter DEPTH):
- Registered storage, pointers and count, with enq/deq/flush inputs and head/valid/full outputs.
- Flush has priority over enq/deq.

instruction_fetch contains the pc register, next-PC/redirect logic and the misaligned flag.

Test Plan:
1. Reset, then out_ready=1, memory returns word = address -> Inst_Address 0,4,8,12 on consecutive cycles; out_pc 0,4,8 lagging by one cycle; out_instr==out_pc; out_valid low only in the first cycle.
2. out_ready=0 from start -> after 2 cycles count=2, Inst_Address holds at 8; set out_ready=1 -> out_pc 0,4,8,12 back-to-back with no bubble.
3. FIFO full (PCs 0,4), redirect=1 with target 0x100 -> out_valid=0 that cycle; next cycle Inst_Address=0x100, out_valid=0; following cycle out_pc=0x100.
4. redirect with target 0x102 -> pc=0x100, misaligned=1 for exactly one cycle, then 0.
5. RESET_PC=0xFFFF_FFFF_FFFF_FFF8 with out_ready=1 -> out_pc ...FFF8, ...FFFC, 0x0, 0x4.
6. Assert reset asynchronously mid-stream (between edges) with 2 entries queued -> out_valid=0 and Inst_Address=RESET_PC immediately; after release the first out_pc is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: datapath widths and
// the {pc, instruction} record that travels from fetch to decode.
package fetch_pkg;

    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instruction} entries until decode
// accepts them. A flush empties it in one edge and overrides enq/deq.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   enq,
    input  entry_t enq_data,
    input  logic   deq,
    output entry_t head,
    output logic   valid,
    output logic   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_enq;
    logic               do_deq;

    // Status flags and head entry; the head reads as zero while empty.
    always_comb begin
        valid = (count_q != '0);
        full  = (count_q == CNT_W'(DEPTH));
        head  = valid ? mem_q[rd_ptr_q] : '0;
    end

    // Qualify requests: a full FIFO only accepts a write when the head is
    // leaving in the same cycle, so the freed slot can be refilled at once.
    always_comb begin
        do_deq = deq & valid & ~flush;
        do_enq = enq & (~full | do_deq) & ~flush;
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) begin
                mem_d[wr_ptr_q] = enq_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : fetch_fifo

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, reads Instruction_Memory
// combinationally at Inst_Address, queues {pc, instruction} in a small FIFO
// and hands entries to decode over valid/ready. A redirect from execute
// flushes everything in flight and restarts at the (word-aligned) target.
module instruction_fetch #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              ILEN     = fetch_pkg::ILEN,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] Inst_Address,
    input  logic [ILEN-1:0] Instruction,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            misaligned
);

    import fetch_pkg::*;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    logic            fifo_valid;
    logic            fifo_full;
    logic            enq;
    logic            deq;
    entry_t          wr_entry;
    entry_t          head;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .enq      (enq),
        .enq_data (wr_entry),
        .deq      (deq),
        .head     (head),
        .valid    (fifo_valid),
        .full     (fifo_full)
    );

    // Handshake: a redirect hides the head so decode never consumes a
    // wrong-path instruction, and blocks fetching in the same cycle.
    always_comb begin
        out_valid = fifo_valid & ~redirect;
        deq       = out_valid & out_ready;
        enq       = ~redirect & (~fifo_full | deq);
        wr_entry  = '{pc: pc_q, instr: Instruction};
    end

    // Next PC: redirect wins, otherwise advance only when a fetch lands so
    // the address stays stable under backpressure.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        if (redirect) begin
            pc_d         = {redirect_target[XLEN-1:2], 2'b00};
            misaligned_d = (redirect_target[1:0] != 2'b00);
        end else if (enq) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
    end

    // PC and misaligned-target flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Output wiring.
    always_comb begin
        Inst_Address = pc_q;
        out_pc       = head.pc;
        out_instr    = head.instr;
        misaligned   = misaligned_q;
    end

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A queue-based model of the
// fetch stage predicts every output; a second instance with a high reset PC
// checks wrap-around of the program counter.
module tb_instruction_fetch;

   localparam int          DEPTH   = 2;
   localparam logic [63:0] HI_PC   = 64'hFFFF_FFFF_FFFF_FFF8;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] Inst_Address;
   logic [31:0] Instruction;
   logic        redirect;
   logic [63:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        misaligned;
   logic [31:0] salt;

   logic [63:0] hi_addr;
   logic [31:0] hi_instr_in;
   logic        hi_valid;
   logic [63:0] hi_pc;
   logic [31:0] hi_instr;
   logic        hi_mis;

   ent_t        q[$];
   logic [63:0] m_pc;
   logic        m_mis;
   int          hi_k;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   // Instruction memory model: word derived from address and a changing salt.
   assign Instruction = Inst_Address[31:0] ^ salt;
   assign hi_instr_in = hi_addr[31:0];

   instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(64'd0)) dut (
      .clk             (clk),
      .reset           (reset),
      .Inst_Address    (Inst_Address),
      .Instruction     (Instruction),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_instr       (out_instr),
      .misaligned      (misaligned)
   );

   instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(HI_PC)) dut_hi (
      .clk             (clk),
      .reset           (reset),
      .Inst_Address    (hi_addr),
      .Instruction     (hi_instr_in),
      .redirect        (1'b0),
      .redirect_target (64'd0),
      .out_valid       (hi_valid),
      .out_ready       (1'b1),
      .out_pc          (hi_pc),
      .out_instr       (hi_instr),
      .misaligned      (hi_mis)
   );

   // Single comparison point: counts, asserts and reports.
   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Compare all outputs of both instances against the model for this cycle.
   task automatic checkOutput();
      ent_t h;
      logic exp_valid;
      exp_valid = (q.size() != 0) && !redirect;
      h = (q.size() != 0) ? q[0] : '{pc: 64'd0, instr: 32'd0};
      checkVal("inst_address", Inst_Address, m_pc);
      checkVal("out_valid",    {63'd0, out_valid}, {63'd0, exp_valid});
      checkVal("out_pc",       out_pc, h.pc);
      checkVal("out_instr",    {32'd0, out_instr}, {32'd0, h.instr});
      checkVal("misaligned",   {63'd0, misaligned}, {63'd0, m_mis});
      if (hi_k < 5) begin
         checkVal("hi_address", hi_addr, HI_PC + 64'(4 * hi_k));
         checkVal("hi_valid",   {63'd0, hi_valid}, {63'd0, (hi_k > 0)});
         checkVal("hi_pc",      hi_pc, (hi_k > 0) ? HI_PC + 64'(4 * (hi_k - 1)) : 64'd0);
         checkVal("hi_instr",   {32'd0, hi_instr},
                  (hi_k > 0) ? {32'd0, HI_PC[31:0] + 32'(4 * (hi_k - 1))} : 64'd0);
      end
   endtask

   task automatic modelReset();
      q.delete();
      m_pc  = 64'd0;
      m_mis = 1'b0;
      hi_k  = 0;
   endtask

   // One clock cycle: drive inputs, check, advance the model, cross the edge.
   task automatic applyStimulus(input logic redir, input logic [63:0] tgt,
                                input logic ready, input logic [31:0] new_salt);
      bit dq;
      bit room;
      redirect        = redir;
      redirect_target = tgt;
      out_ready       = ready;
      salt            = new_salt;
      #2;
      checkOutput();
      if (redir) begin
         q.delete();
         m_pc  = {tgt[63:2], 2'b00};
         m_mis = (tgt[1:0] != 2'b00);
      end else begin
         m_mis = 1'b0;
         dq    = (q.size() != 0) && ready;
         room  = (q.size() < DEPTH) || dq;
         if (dq) void'(q.pop_front());
         if (room) begin
            q.push_back('{pc: m_pc, instr: m_pc[31:0] ^ new_salt});
            m_pc = m_pc + 64'd4;
         end
      end
      hi_k++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset           = 1'b1;
      redirect        = 1'b0;
      redirect_target = 64'd0;
      out_ready       = 1'b0;
      salt            = 32'd0;
      modelReset();
      @(posedge clk);
      #2;
      $display("[TB] reset state");
      checkVal("rst_address", Inst_Address, 64'd0);
      checkVal("rst_valid",   {63'd0, out_valid}, 64'd0);
      checkVal("rst_pc",      out_pc, 64'd0);
      checkVal("rst_instr",   {32'd0, out_instr}, 64'd0);
      checkVal("rst_mis",     {63'd0, misaligned}, 64'd0);
      checkVal("rst_hi_addr", hi_addr, HI_PC);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] streaming with ready high, word = address");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'd0, 1'b1, 32'd0);

      $display("[TB] backpressure then release");
      applyStimulus(1'b1, 64'd0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'd0, 1'b1, 32'd0);

      $display("[TB] redirect while full");
      applyStimulus(1'b1, 64'd0, 1'b0, 32'd0);
      applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
      applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
      applyStimulus(1'b1, 64'h100, 1'b1, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'd0, 1'b1, 32'd0);

      $display("[TB] misaligned redirect and back-to-back redirects");
      applyStimulus(1'b1, 64'h102, 1'b1, 32'd0);
      applyStimulus(1'b0, 64'd0, 1'b1, 32'd0);
      applyStimulus(1'b0, 64'd0, 1'b1, 32'd0);
      applyStimulus(1'b1, 64'h203, 1'b1, 32'd0);
      applyStimulus(1'b1, 64'h400, 1'b1, 32'd0);
      applyStimulus(1'b0, 64'd0, 1'b1, 32'd0);
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 64'd0, 1'b1, 32'd0);

      $display("[TB] asynchronous reset with entries queued");
      applyStimulus(1'b1, 64'h800, 1'b0, 32'd0);
      applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
      applyStimulus(1'b0, 64'd0, 1'b0, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      checkVal("async_valid", {63'd0, out_valid}, 64'd0);
      checkVal("async_addr",  Inst_Address, 64'd0);
      checkVal("async_pc",    out_pc, 64'd0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'd0, 1'b1, 32'd0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         logic [63:0] tgt;
         logic        redir;
         logic        ready;
         tgt   = {$urandom, $urandom};
         if ($urandom_range(3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
         redir = ($urandom_range(7) == 0);
         ready = ($urandom_range(3) != 0);
         applyStimulus(redir, tgt, ready, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_instruction_fetch
